// File: rtl/alu_share_ctrl_if.sv
// Bus bundle between the two requesters, the shared-ALU controller, the ALU and the response consumer.
// The slave modport is the controller's view; the master modport is the surrounding datapath's view.
interface alu_share_ctrl_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MUL_WIDTH = 12
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic [3:0]           req0_opsel;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic [3:0]           req1_opsel;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [3:0]           alu_opsel;
    logic [MUL_WIDTH-1:0] alu_result;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [MUL_WIDTH-1:0] rsp_result;
    logic                 rsp_id;
    logic                 rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_opsel,
        input  req1_valid, req1_a, req1_b, req1_opsel,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_opsel,
        output rsp_valid, rsp_result, rsp_id, rsp_err
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_opsel,
        output req1_valid, req1_a, req1_b, req1_opsel,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_opsel,
        input  rsp_valid, rsp_result, rsp_id, rsp_err
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin front end sharing one external combinational ALU between two requesters.
// One operation in flight: accept (IDLE) -> let ALU settle (ISSUE) -> hold response (RESP).
module alu_share_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MUL_WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    alu_share_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e               state_q;
    logic                 last_grant_q;
    logic                 id_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [3:0]           opsel_q;
    logic                 rsp_valid_q;
    logic [MUL_WIDTH-1:0] rsp_result_q;
    logic                 rsp_id_q;
    logic                 rsp_err_q;

    logic grant0, grant1;
    logic acc0, acc1;
    logic op_err;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
        end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
        end
    end

    assign acc0   = (state_q == IDLE) && grant0;
    assign acc1   = (state_q == IDLE) && grant1;
    assign op_err = (opsel_q >= 4'd11) || ((opsel_q == 4'd5) && (b_q == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            opsel_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc0) begin
                        a_q          <= bus.req0_a;
                        b_q          <= bus.req0_b;
                        opsel_q      <= bus.req0_opsel;
                        id_q         <= 1'b0;
                        last_grant_q <= 1'b0;
                        state_q      <= ISSUE;
                    end else if (acc1) begin
                        a_q          <= bus.req1_a;
                        b_q          <= bus.req1_b;
                        opsel_q      <= bus.req1_opsel;
                        id_q         <= 1'b1;
                        last_grant_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_result_q <= op_err ? '0 : bus.alu_result;
                    rsp_err_q    <= op_err;
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_opsel  = opsel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU attached to the ALU ports.
module tb_alu_share_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    alu_share_ctrl_if #(.WIDTH(8), .MUL_WIDTH(12)) bus ();

    alu_share_ctrl #(.WIDTH(8), .MUL_WIDTH(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in ALU; unused opcodes and divide-by-zero give nonzero junk the controller must suppress.
    function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return {4'd0, a} + {4'd0, b};
            4'd1:    return {4'd0, a} - {4'd0, b};
            4'd2:    return {4'd0, a} * {4'd0, b};
            4'd3:    return {4'd0, a & b};
            4'd5:    return (b == 8'd0) ? 12'hFFF : {4'd0, a / b};
            4'd8:    return {4'd0, a ^ b};
            4'd9:    return {4'd0, a | b};
            4'd10:   return (a < b) ? 12'd1 : 12'd0;
            default: return 12'hABC;
        endcase
    endfunction

    always_comb bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_opsel);

    typedef struct {
        string      name;
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [11:0] exp_res;
        logic       exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_opsel = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_opsel = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive_req(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_opsel = op;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_opsel = op;
        end
    endtask

    // Single-requester operation from IDLE with rsp_ready held high; entered just after a rising edge.
    task automatic run_vec(input vec_t v);
        drive_req(v.id, v.a, v.b, v.op);
        #1;
        chk({v.name, "_rdy_granted"}, v.id ? bus.req1_ready : bus.req0_ready, 1);
        chk({v.name, "_rdy_other"},   v.id ? bus.req0_ready : bus.req1_ready, 0);
        @(posedge clk); #1;
        clear_reqs();
        chk({v.name, "_issue_rdy"}, {bus.req0_ready, bus.req1_ready}, 0);
        chk({v.name, "_alu_a"}, bus.alu_a, v.a);
        chk({v.name, "_alu_opsel"}, bus.alu_opsel, v.op);
        chk({v.name, "_issue_valid"}, bus.rsp_valid, 0);
        @(posedge clk); #1;
        chk({v.name, "_rsp_valid"}, bus.rsp_valid, 1);
        chk({v.name, "_rsp_result"}, bus.rsp_result, v.exp_res);
        chk({v.name, "_rsp_id"}, bus.rsp_id, v.id);
        chk({v.name, "_rsp_err"}, bus.rsp_err, v.exp_err);
        @(posedge clk); #1;
        chk({v.name, "_done_valid"}, bus.rsp_valid, 0);
        chk({v.name, "_alu_b_hold"}, bus.alu_b, v.b);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cyc;
        int last_cyc;
        logic [11:0] rr_res[3];
        logic        rr_id[3];

        vecs[0]  = '{"add",      1'b0, 8'd103, 8'd84,  4'd0,  12'd187,  1'b0};
        vecs[1]  = '{"mul",      1'b1, 8'd39,  8'd31,  4'd2,  12'd1209, 1'b0};
        vecs[2]  = '{"xor",      1'b1, 8'd9,   8'd6,   4'd8,  12'd15,   1'b0};
        vecs[3]  = '{"or",       1'b0, 8'd8,   8'd71,  4'd9,  12'd79,   1'b0};
        vecs[4]  = '{"div0",     1'b0, 8'd102, 8'd0,   4'd5,  12'd0,    1'b1};
        vecs[5]  = '{"div",      1'b1, 8'd100, 8'd7,   4'd5,  12'd14,   1'b0};
        vecs[6]  = '{"op13",     1'b1, 8'd20,  8'd3,   4'd13, 12'd0,    1'b1};
        vecs[7]  = '{"op10",     1'b0, 8'd3,   8'd5,   4'd10, 12'd1,    1'b0};
        vecs[8]  = '{"op11",     1'b0, 8'd1,   8'd1,   4'd11, 12'd0,    1'b1};
        vecs[9]  = '{"op15",     1'b1, 8'd255, 8'd255, 4'd15, 12'd0,    1'b1};
        vecs[10] = '{"sub",      1'b0, 8'd10,  8'd3,   4'd1,  12'd7,    1'b0};

        bus.rsp_ready = 1'b1;
        do_reset();

        chk("rst_rsp_valid",  bus.rsp_valid, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_id",     bus.rsp_id, 0);
        chk("rst_rsp_err",    bus.rsp_err, 0);
        chk("rst_alu_ops",    {bus.alu_a, bus.alu_b, bus.alu_opsel}, 0);
        chk("rst_readies",    {bus.req0_ready, bus.req1_ready}, 0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Both requesters held valid: req0 first after reset, then alternation every 3 cycles.
        do_reset();
        drive_req(1'b0, 8'd39, 8'd31, 4'd2);
        drive_req(1'b1, 8'd9, 8'd6, 4'd8);
        rr_res[0] = 12'd1209; rr_id[0] = 1'b0;
        rr_res[1] = 12'd15;   rr_id[1] = 1'b1;
        rr_res[2] = 12'd1209; rr_id[2] = 1'b0;
        n = 0; cyc = 0; last_cyc = 0;
        while (n < 3 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.rsp_valid) begin
                chk($sformatf("rr%0d_result", n), bus.rsp_result, rr_res[n]);
                chk($sformatf("rr%0d_id", n), bus.rsp_id, rr_id[n]);
                if (n > 0) chk($sformatf("rr%0d_spacing", n), cyc - last_cyc, 3);
                last_cyc = cyc;
                n++;
            end
        end
        chk("rr_count", n, 3);
        clear_reqs();
        @(posedge clk); #1;

        // Backpressure: response held for 5 cycles, pending req0 waits until RESP is left.
        do_reset();
        bus.rsp_ready = 1'b0;
        drive_req(1'b1, 8'd8, 8'd71, 4'd9);
        @(posedge clk); #1;
        clear_reqs();
        drive_req(1'b0, 8'd103, 8'd84, 4'd0);
        cyc = 0;
        while (!bus.rsp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_rsp_seen", bus.rsp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), bus.rsp_valid, 1);
            chk($sformatf("bp%0d_result", k), bus.rsp_result, 79);
            chk($sformatf("bp%0d_id", k), bus.rsp_id, 1);
            chk($sformatf("bp%0d_readies", k), {bus.req0_ready, bus.req1_ready}, 0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_rdy0", bus.req0_ready, 0);
        @(posedge clk); #1;
        chk("bp_idle_valid", bus.rsp_valid, 0);
        chk("bp_idle_rdy0", bus.req0_ready, 1);
        @(posedge clk); #1;
        clear_reqs();
        chk("bp_req0_alu_a", bus.alu_a, 103);
        @(posedge clk); #1;
        chk("bp_req0_result", bus.rsp_result, 187);
        chk("bp_req0_id", bus.rsp_id, 0);
        @(posedge clk); #1;

        // Reset while in ISSUE discards the operation and restores req0 priority.
        drive_req(1'b1, 8'd1, 8'd2, 4'd0);
        @(posedge clk); #1;
        clear_reqs();
        rst = 1'b1;
        #1;
        chk("rstmid_valid", bus.rsp_valid, 0);
        chk("rstmid_alu_a", bus.alu_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_no_rsp", bus.rsp_valid, 0);
        drive_req(1'b0, 8'd1, 8'd2, 4'd0);
        drive_req(1'b1, 8'd5, 8'd5, 4'd0);
        #1;
        chk("rstmid_rdy0", bus.req0_ready, 1);
        chk("rstmid_rdy1", bus.req1_ready, 0);
        @(posedge clk); #1;
        clear_reqs();
        @(posedge clk); #1;
        chk("rstmid_result", bus.rsp_result, 3);
        chk("rstmid_id", bus.rsp_id, 0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
